// File: rtl/ray_march_scheduler_pkg.sv
// Shared fixed-point / vector types and helpers for the ray-march scheduler.
package ray_march_scheduler_pkg;

   // Signed Q16.16
   typedef logic signed [31:0] fp;

   typedef struct packed {
      fp x;
      fp y;
      fp z;
   } vec3;

   localparam fp FP_ONE     = 32'sh0001_0000;
   localparam fp FP_HALF    = 32'sh0000_8000;
   localparam fp FP_QUARTER = 32'sh0000_4000;
   localparam fp FP_MAX     = 32'sh7FFF_FFFF;
   localparam fp FP_MIN     = 32'sh8000_0000;

   typedef enum logic [1:0] {
      FREE,
      ISSUE,
      WAIT,
      DONE
   } slot_state_t;

   function automatic vec3 make_vec3(input fp x, input fp y, input fp z);
      vec3 v;
      v.x = x;
      v.y = y;
      v.z = z;
      return v;
   endfunction

   function automatic vec3 vec3_add(input vec3 a, input vec3 b);
      return make_vec3(a.x + b.x, a.y + b.y, a.z + b.z);
   endfunction

   // Full-precision product, rescaled back to Q16.16 (floor).
   function automatic fp fp_mul(input fp a, input fp b);
      logic signed [63:0] pa;
      logic signed [63:0] pb;
      pa = a;
      pb = b;
      return fp'((pa * pb) >>> 16);
   endfunction

   // Clamps to the representable range instead of wrapping.
   function automatic fp fp_add_sat(input fp a, input fp b);
      logic [32:0] s;
      s = {a[31], a} + {b[31], b};
      if (s[32] != s[31]) return s[32] ? FP_MIN : FP_MAX;
      return s[31:0];
   endfunction

endpackage

// File: rtl/ray_march_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner on adv.
module ray_march_scheduler_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         adv,
   output logic [N-1:0] gnt
);
   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] win, idx;
   logic          any;

   // Scan from the pointer with wrap; the smallest offset from the pointer wins.
   always_comb begin
      win = '0;
      any = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = ptr_q + IW'(i);
         if (req[idx]) begin
            win = idx;
            any = 1'b1;
         end
      end
      gnt   = any ? (N'(1) << win) : '0;
      ptr_d = (adv && any) ? win + IW'(1) : ptr_q;
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
endmodule

// File: rtl/ray_march_scheduler.sv
// Sphere-tracing scheduler: time-shares one fixed-latency SDF pipe across
// NUM_SLOTS ray contexts.
//
// state | meaning
// FREE  | slot empty, may accept a new ray
// ISSUE | ray needs its next sample, competing for the SDF pipe
// WAIT  | sample in flight, tag travelling alongside in the tag pipe
// DONE  | ray retired, waiting for the result port
module ray_march_scheduler
   import ray_march_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS   = 4,
   parameter int SDF_LATENCY = 1,
   parameter int MAX_STEPS   = 64,
   parameter fp  HIT_EPS     = 32'sh0000_0080,
   parameter fp  T_MAX       = 32'sh0004_0000,
   parameter int ID_W        = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ray_valid,
   output logic            ray_ready,
   input  logic [ID_W-1:0] ray_id,
   input  vec3             ray_origin,
   input  vec3             ray_dir,
   output logic            sdf_valid_in,
   output vec3             sdf_point,
   input  logic            sdf_valid_out,
   input  fp               sdf_distance,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [ID_W-1:0] res_id,
   output logic            res_hit,
   output fp               res_t,
   output logic [7:0]      res_steps
);
   localparam int SW = $clog2(NUM_SLOTS);
   localparam int TD = SDF_LATENCY + 1;

   slot_state_t     state_q [NUM_SLOTS], state_d [NUM_SLOTS];
   fp               t_q     [NUM_SLOTS], t_d     [NUM_SLOTS];
   logic [7:0]      steps_q [NUM_SLOTS], steps_d [NUM_SLOTS];
   logic            hit_q   [NUM_SLOTS], hit_d   [NUM_SLOTS];
   logic [ID_W-1:0] id_q    [NUM_SLOTS], id_d    [NUM_SLOTS];
   vec3             org_q   [NUM_SLOTS], org_d   [NUM_SLOTS];
   vec3             dir_q   [NUM_SLOTS], dir_d   [NUM_SLOTS];

   logic            tag_v_q   [TD], tag_v_d   [TD];
   logic [SW-1:0]   tag_idx_q [TD], tag_idx_d [TD];

   logic            sdf_valid_q, sdf_valid_d;
   vec3             sdf_point_q, sdf_point_d;

   logic            res_valid_q, res_valid_d;
   logic [SW-1:0]   res_slot_q, res_slot_d;
   logic [ID_W-1:0] res_id_q, res_id_d;
   logic            res_hit_q, res_hit_d;
   fp               res_t_q, res_t_d;
   logic [7:0]      res_steps_q, res_steps_d;

   logic [NUM_SLOTS-1:0] free_vec, issue_req, done_req, iss_gnt, res_gnt;
   logic [SW-1:0]   acc_idx, iss_idx, res_idx, ret_idx;
   logic            accept, iss_valid, res_take, res_hs, ret_valid;
   logic            ret_hit, ret_far, ret_exhaust;
   logic [7:0]      steps_inc;
   fp               t_sum;
   vec3             iss_point;

   // Slot status decode; the slot parked in the result register is not re-offered.
   always_comb begin
      free_vec  = '0;
      issue_req = '0;
      done_req  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         free_vec[i]  = (state_q[i] == FREE);
         issue_req[i] = (state_q[i] == ISSUE);
         done_req[i]  = (state_q[i] == DONE) && !(res_valid_q && (res_slot_q == SW'(i)));
      end
   end

   assign ray_ready = !rst && (|free_vec);
   assign accept    = ray_valid && ray_ready;
   assign res_take  = !res_valid_q || res_ready;
   assign res_hs    = res_valid_q && res_ready;

   ray_march_scheduler_rr_arbiter #(.N(NUM_SLOTS)) u_issue_arb (
      .clk (clk),
      .rst (rst),
      .req (issue_req),
      .adv (1'b1),
      .gnt (iss_gnt)
   );

   ray_march_scheduler_rr_arbiter #(.N(NUM_SLOTS)) u_res_arb (
      .clk (clk),
      .rst (rst),
      .req (done_req),
      .adv (res_take),
      .gnt (res_gnt)
   );

   // Slot index selection: lowest free slot for accept, one-hot decode of grants.
   always_comb begin
      acc_idx = '0;
      iss_idx = '0;
      res_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free_vec[i]) acc_idx = SW'(i);
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (iss_gnt[i]) iss_idx = SW'(i);
         if (res_gnt[i]) res_idx = SW'(i);
      end
      iss_valid = |iss_gnt;
   end

   // Return decode: hit wins over both the distance limit and the step budget.
   always_comb begin
      ret_valid   = sdf_valid_out && tag_v_q[TD-1];
      ret_idx     = tag_idx_q[TD-1];
      steps_inc   = steps_q[ret_idx] + 8'd1;
      t_sum       = fp_add_sat(t_q[ret_idx], sdf_distance);
      ret_hit     = (sdf_distance < HIT_EPS);
      ret_far     = (t_sum > T_MAX);
      ret_exhaust = (steps_inc == 8'(MAX_STEPS));
   end

   // Slot context next state: accept, grant, return and result release hit disjoint slots.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      steps_d = steps_q;
      hit_d   = hit_q;
      id_d    = id_q;
      org_d   = org_q;
      dir_d   = dir_q;
      if (accept) begin
         state_d[acc_idx] = ISSUE;
         t_d[acc_idx]     = '0;
         steps_d[acc_idx] = '0;
         hit_d[acc_idx]   = 1'b0;
         id_d[acc_idx]    = ray_id;
         org_d[acc_idx]   = ray_origin;
         dir_d[acc_idx]   = ray_dir;
      end
      if (iss_valid) state_d[iss_idx] = WAIT;
      if (ret_valid) begin
         steps_d[ret_idx] = steps_inc;
         if (ret_hit) begin
            state_d[ret_idx] = DONE;
            hit_d[ret_idx]   = 1'b1;
         end else if (ret_far || ret_exhaust) begin
            state_d[ret_idx] = DONE;
            hit_d[ret_idx]   = 1'b0;
         end else begin
            state_d[ret_idx] = ISSUE;
            t_d[ret_idx]     = t_sum;
         end
      end
      if (res_hs) state_d[res_slot_q] = FREE;
   end

   // Issue datapath and tag pipe aligned to the SDF return.
   always_comb begin
      iss_point   = vec3_add(org_q[iss_idx],
                             make_vec3(fp_mul(t_q[iss_idx], dir_q[iss_idx].x),
                                       fp_mul(t_q[iss_idx], dir_q[iss_idx].y),
                                       fp_mul(t_q[iss_idx], dir_q[iss_idx].z)));
      sdf_valid_d = iss_valid;
      sdf_point_d = iss_valid ? iss_point : sdf_point_q;
      tag_v_d[0]   = iss_valid;
      tag_idx_d[0] = iss_idx;
      for (int k = 1; k < TD; k++) begin
         tag_v_d[k]   = tag_v_q[k-1];
         tag_idx_d[k] = tag_idx_q[k-1];
      end
   end

   // Result register: reload on empty or on handshake, otherwise hold.
   always_comb begin
      res_valid_d = res_valid_q;
      res_slot_d  = res_slot_q;
      res_id_d    = res_id_q;
      res_hit_d   = res_hit_q;
      res_t_d     = res_t_q;
      res_steps_d = res_steps_q;
      if (res_take) begin
         res_valid_d = |res_gnt;
         if (|res_gnt) begin
            res_slot_d  = res_idx;
            res_id_d    = id_q[res_idx];
            res_hit_d   = hit_q[res_idx];
            res_t_d     = t_q[res_idx];
            res_steps_d = steps_q[res_idx];
         end
      end
   end

   // State registers; reset drops every context and any sample in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            state_q[i] <= FREE;
            t_q[i]     <= '0;
            steps_q[i] <= '0;
            hit_q[i]   <= 1'b0;
            id_q[i]    <= '0;
            org_q[i]   <= '0;
            dir_q[i]   <= '0;
         end
         for (int k = 0; k < TD; k++) begin
            tag_v_q[k]   <= 1'b0;
            tag_idx_q[k] <= '0;
         end
         sdf_valid_q <= 1'b0;
         sdf_point_q <= '0;
         res_valid_q <= 1'b0;
         res_slot_q  <= '0;
         res_id_q    <= '0;
         res_hit_q   <= 1'b0;
         res_t_q     <= '0;
         res_steps_q <= '0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         steps_q     <= steps_d;
         hit_q       <= hit_d;
         id_q        <= id_d;
         org_q       <= org_d;
         dir_q       <= dir_d;
         tag_v_q     <= tag_v_d;
         tag_idx_q   <= tag_idx_d;
         sdf_valid_q <= sdf_valid_d;
         sdf_point_q <= sdf_point_d;
         res_valid_q <= res_valid_d;
         res_slot_q  <= res_slot_d;
         res_id_q    <= res_id_d;
         res_hit_q   <= res_hit_d;
         res_t_q     <= res_t_d;
         res_steps_q <= res_steps_d;
      end
   end

   assign sdf_valid_in = sdf_valid_q;
   assign sdf_point    = sdf_point_q;
   assign res_valid    = res_valid_q;
   assign res_id       = res_id_q;
   assign res_hit      = res_hit_q;
   assign res_t        = res_t_q;
   assign res_steps    = res_steps_q;
endmodule

// File: tb/tb_ray_march_scheduler.sv
// Bench for ray_march_scheduler: behavioural SDF pipe, table of single-ray
// vectors, id-matched result scoreboard, and multi-cycle corner sequences.
module tb_ray_march_scheduler;
   import ray_march_scheduler_pkg::*;

   localparam int NS  = 4;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        ray_valid, ray_ready;
   logic [15:0] ray_id;
   vec3         ray_origin, ray_dir;
   logic        sdf_valid_in;
   vec3         sdf_point;
   logic        sdf_valid_out;
   fp           sdf_distance;
   logic        res_valid, res_ready;
   logic [15:0] res_id;
   logic        res_hit;
   fp           res_t;
   logic [7:0]  res_steps;

   always #5 clk = ~clk;

   ray_march_scheduler #(
      .NUM_SLOTS   (NS),
      .SDF_LATENCY (LAT),
      .MAX_STEPS   (64),
      .HIT_EPS     (32'sh0000_0080),
      .T_MAX       (32'sh0004_0000),
      .ID_W        (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ray_valid     (ray_valid),
      .ray_ready     (ray_ready),
      .ray_id        (ray_id),
      .ray_origin    (ray_origin),
      .ray_dir       (ray_dir),
      .sdf_valid_in  (sdf_valid_in),
      .sdf_point     (sdf_point),
      .sdf_valid_out (sdf_valid_out),
      .sdf_distance  (sdf_distance),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_id        (res_id),
      .res_hit       (res_hit),
      .res_t         (res_t),
      .res_steps     (res_steps)
   );

   typedef struct {
      logic [15:0] id;
      int          mode;
      vec3         o;
      vec3         d;
      logic        hit;
      fp           t;
      logic [7:0]  steps;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   mode = 0;
   int   issue_cnt = 0;
   int   stray_cnt = 0;
   vec_t sbq[$];
   int   hs_log[$];
   fp    issue_log[$];

   // Bench SDF unit: fixed LAT, no reset, so reset leaves stale returns in flight.
   logic pv [LAT];
   fp    pd [LAT];

   function automatic fp sdf_model(input vec3 p, input int m);
      fp d;
      case (m)
         1: d = (p.x == 0) ? FP_ONE : ((p.x == FP_ONE) ? FP_HALF : 32'sd66);
         2: d = FP_QUARTER;
         3: d = 32'sd655;
         4: d = (p.y != 0) ? 32'sd0 : FP_QUARTER;
         5: d = (p.x >= 32'sd41265) ? 32'sd0 : 32'sd655;
         default: d = FP_ONE;
      endcase
      return d;
   endfunction

   always @(posedge clk) begin
      cyc++;
      pv[0] <= sdf_valid_in;
      pd[0] <= sdf_model(sdf_point, mode);
      for (int k = 1; k < LAT; k++) begin
         pv[k] <= pv[k-1];
         pd[k] <= pd[k-1];
      end
   end
   assign sdf_valid_out = pv[LAT-1];
   assign sdf_distance  = pd[LAT-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] id, input int m, input vec3 o, input vec3 d,
                               input logic hit, input fp t, input logic [7:0] steps);
      vec_t v;
      v.id = id; v.mode = m; v.o = o; v.d = d; v.hit = hit; v.t = t; v.steps = steps;
      return v;
   endfunction

   // Result monitor: scoreboard match by id, and stability while stalled.
   logic        prev_hold = 1'b0;
   logic [15:0] h_id;
   logic        h_hit;
   fp           h_t;
   logic [7:0]  h_steps;

   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", res_valid, 1'b1);
            chk("hold_id", res_id, h_id);
            chk("hold_hit", res_hit, h_hit);
            chk("hold_t", res_t, h_t);
            chk("hold_steps", res_steps, h_steps);
         end
         if (sdf_valid_in) begin
            issue_cnt++;
            if (issue_log.size() < 4) issue_log.push_back(sdf_point.x);
         end
         if (res_valid && res_ready) begin
            int k;
            k = -1;
            hs_log.push_back(cyc);
            foreach (sbq[j]) if (k < 0 && sbq[j].id == res_id) k = j;
            if (k < 0) begin
               checks++;
               failures++;
               $display("FAIL res_id actual=%0h required=a pending ray id", res_id);
            end else begin
               chk($sformatf("res_hit_id%0d", res_id), res_hit, sbq[k].hit);
               chk($sformatf("res_t_id%0d", res_id), res_t, sbq[k].t);
               chk($sformatf("res_steps_id%0d", res_id), res_steps, sbq[k].steps);
               sbq.delete(k);
            end
         end
         prev_hold = res_valid && !res_ready;
         h_id = res_id; h_hit = res_hit; h_t = res_t; h_steps = res_steps;
      end
   end

   task automatic send_ray(input vec_t v, output int acc_cyc);
      int w;
      logic ok;
      w = 0;
      ok = 1'b0;
      acc_cyc = -1;
      ray_valid = 1'b1; ray_id = v.id; ray_origin = v.o; ray_dir = v.d;
      while (!ok && w < 500) begin
         @(negedge clk);
         if (ray_ready) begin ok = 1'b1; acc_cyc = cyc; end
         else w++;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL accept_timeout id=%0h actual=not accepted required=accepted", v.id);
      end
      @(posedge clk); #1;
      ray_valid = 1'b0;
      if (ok) sbq.push_back(v);
   endtask

   task automatic wait_drain(input int budget);
      int w;
      w = 0;
      while (sbq.size() != 0 && w < budget) begin
         @(posedge clk); #1;
         w++;
      end
      if (sbq.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=%0d pending required=0", sbq.size());
      end
   endtask

   vec_t tbl[6];
   int   acc[5];

   initial begin
      vec3 z3, dx;
      int  c0, n0;
      for (int k = 0; k < LAT; k++) begin pv[k] = 1'b0; pd[k] = '0; end
      z3 = make_vec3(0, 0, 0);
      dx = make_vec3(FP_ONE, 0, 0);
      rst = 1'b1; ray_valid = 1'b0; ray_id = '0; ray_origin = z3; ray_dir = z3; res_ready = 1'b1;

      tbl[0] = mk(16'd7,  1, z3, dx, 1'b1, 32'sh0001_8000, 8'd3);
      tbl[1] = mk(16'd8,  2, z3, dx, 1'b0, 32'sh0004_0000, 8'd17);
      tbl[2] = mk(16'd9,  3, z3, dx, 1'b0, 32'sh0000_A131, 8'd64);
      tbl[3] = mk(16'd10, 5, z3, dx, 1'b1, 32'sh0000_A131, 8'd64);
      tbl[4] = mk(16'd11, 4, make_vec3(0, FP_ONE, 0), dx, 1'b1, 32'sh0, 8'd1);
      tbl[5] = mk(16'd12, 2, make_vec3(FP_HALF, -32'sh0002_0000, 32'sh0003_0000),
                  make_vec3(0, 0, -FP_ONE), 1'b0, 32'sh0004_0000, 8'd17);

      // Reset state.
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("ready_in_reset", ray_ready, 1'b0);
      chk("sdf_valid_in_reset", sdf_valid_in, 1'b0);
      chk("res_valid_in_reset", res_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", ray_ready, 1'b1);
      @(posedge clk); #1;

      // Single-ray vectors.
      for (int i = 0; i < 6; i++) begin
         mode = tbl[i].mode;
         send_ray(tbl[i], c0);
         wait_drain(2000);
      end

      // Five rays back-to-back into four slots.
      mode = 2;
      issue_log.delete();
      hs_log.delete();
      for (int i = 0; i < 5; i++)
         send_ray(mk(16'(20 + i), 2, make_vec3(fp'(i) <<< 16, 0, 0), dx,
                     1'b0, 32'sh0004_0000, 8'd17), acc[i]);
      for (int i = 1; i < 4; i++) chk($sformatf("accept_cycle_%0d", i), acc[i] - acc[0], i);
      chk("fifth_accept_after_first_result", acc[4] - ((hs_log.size() > 0) ? hs_log[0] : -100), 1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("grant_order_%0d", i), (issue_log.size() > i) ? issue_log[i] : -1, fp'(i) <<< 16);
      wait_drain(2000);

      // Stalled result port with two retired rays while two others march.
      mode = 4;
      res_ready = 1'b0;
      send_ray(mk(16'd30, 4, make_vec3(0, FP_ONE, 0), dx, 1'b1, 32'sh0, 8'd1), c0);
      send_ray(mk(16'd31, 4, make_vec3(0, FP_ONE, 0), dx, 1'b1, 32'sh0, 8'd1), c0);
      send_ray(mk(16'd32, 4, z3, dx, 1'b0, 32'sh0004_0000, 8'd17), c0);
      send_ray(mk(16'd33, 4, z3, dx, 1'b0, 32'sh0004_0000, 8'd17), c0);
      c0 = 0;
      while (!res_valid && c0 < 200) begin @(posedge clk); #1; c0++; end
      chk("stall_res_valid_seen", res_valid, 1'b1);
      n0 = issue_cnt;
      repeat (20) @(posedge clk);
      chk("issue_during_stall", (issue_cnt - n0) > 0, 1'b1);
      #1;
      hs_log.delete();
      res_ready = 1'b1;
      c0 = 0;
      while (hs_log.size() < 2 && c0 < 50) begin @(posedge clk); #1; c0++; end
      chk("release_consecutive", (hs_log.size() >= 2) ? hs_log[1] - hs_log[0] : -1, 1);
      wait_drain(2000);

      // Reset with three rays in flight; stale returns must be ignored.
      mode = 2;
      for (int i = 0; i < 3; i++)
         send_ray(mk(16'(40 + i), 2, z3, dx, 1'b0, 32'sh0004_0000, 8'd17), c0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("ready_in_mid_reset", ray_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      sbq.delete();
      stray_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) chk("ready_after_mid_reset", ray_ready, 1'b1);
         if (sdf_valid_out) stray_cnt++;
         chk("no_result_after_reset", res_valid, 1'b0);
      end
      chk("stray_returns_present", stray_cnt > 0, 1'b1);
      @(posedge clk); #1;
      mode = 1;
      send_ray(mk(16'd50, 1, z3, dx, 1'b1, 32'sh0001_8000, 8'd3), c0);
      wait_drain(2000);

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
